// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular instruction queue between the fetch and decode
//               stages. Each entry holds a {PC, instruction} pair. Handshake
//               flags come from registered occupancy only; a redirect (flush)
//               empties the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic            clk,
  input  logic            reset,      // asynchronous, active-low
  input  logic            in_valid,
  input  logic [31:0]     in_pc,
  input  logic [31:0]     in_instr,
  output logic            in_ready,
  output logic            out_valid,
  output logic [31:0]     out_pc,
  output logic [31:0]     out_instr,
  input  logic            out_ready,
  input  logic            flush,
  output logic [PTRW:0]   count
);

  localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
  localparam logic [PTRW:0]   CNT_ONE  = (PTRW + 1)'(1);
  localparam logic [PTRW:0]   CNT_FULL = (PTRW + 1)'(DEPTH);

  // Storage is not reset; it is never visible while out_valid is low.
  logic [63:0]     mem_q [DEPTH];

  logic [PTRW-1:0] head_q, head_d;
  logic [PTRW-1:0] tail_q, tail_d;
  logic [PTRW:0]   count_q, count_d;

  logic            w_push;
  logic            w_pop;

  // Handshake flags depend only on the registered occupancy.
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // A flush overrides both transfers on the same edge.
  assign w_push = in_valid & in_ready  & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  // Head entry is gated to zero whenever the queue is empty.
  always_comb begin
    out_pc    = 32'h0;
    out_instr = 32'h0;
    if (out_valid) begin
      out_pc    = mem_q[head_q][63:32];
      out_instr = mem_q[head_q][31:0];
    end
  end

  // Next-state for pointers and occupancy; power-of-two depth gives the wrap.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_push) tail_d = tail_q + PTR_ONE;
      if (w_pop)  head_d = head_q + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write the accepted pair at the tail; pops leave storage untouched.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[tail_q] <= {in_pc, in_instr};
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter PTRW, default 2, pointer width = log2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port in_valid  input  1  fetch stage presents a {PC, instruction} pair.
REQ-006 SHALL have port in_pc  input  32  PC of the presented instruction.
REQ-007 SHALL have port in_instr  input  32  fetched instruction word.
REQ-008 SHALL have port in_ready  output  1  queue can accept; drives the fetch stage PC-update enable.
REQ-009 SHALL have port out_valid  output  1  head entry valid for decode.
REQ-010 SHALL have port out_pc  output  32  PC of head entry.
REQ-011 SHALL have port out_instr  output  32  instruction of head entry.
REQ-012 SHALL have port out_ready  input  1  decode consumes head this cycle.
REQ-013 SHALL have port flush  input  1  branch/jump redirect; discard all queued and presented entries.
REQ-014 SHALL have port count  output  PTRW+1  current occupancy, 0..DEPTH.

Function
REQ-015 SHALL push when in_valid and in_ready and not flush; entry written at tail, tail pointer increments.
REQ-016 SHALL pop when out_valid and out_ready and not flush; head pointer increments.
REQ-017 SHALL wrap head and tail pointers modulo DEPTH (DEPTH-1 -> 0).
REQ-018 SHALL update count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 SHALL drive in_ready = (count != DEPTH), from registered state only, no combinational dependence on out_ready.
REQ-020 SHALL drive out_valid = (count != 0), from registered state only.
REQ-021 SHALL provide one-cycle minimum latency: entry pushed at edge N appears on out_* after edge N, never combinationally bypassed in the same cycle.
REQ-022 SHALL present out_pc and out_instr from the head entry when out_valid=1, and drive both to 32'h0 when out_valid=0.
REQ-023 SHALL preserve FIFO order; entries leave in exactly the order accepted.
REQ-024 SHALL, on flush=1 at an edge, set count=0 and head=tail=0, ignoring any simultaneous push or pop.
REQ-025 SHALL hold contents, pointers and count unchanged when neither push nor pop nor flush occurs.
REQ-026 SHALL treat in_valid while full as no-op (entry not stored, no error state); the fetch stage holds its PC because in_ready=0.
REQ-027 SHALL treat out_ready while empty as no-op; count never underflows.
REQ-028 SHALL allow push and pop in the same cycle at any occupancy 1..DEPTH-1 with data of both entries intact.
REQ-029 SHALL not alter entry storage contents on pop; only pointers and count move.

Reset
REQ-030 SHALL, while reset=0, asynchronously force head=0, tail=0, count=0, out_valid=0, in_ready=1, out_pc=0, out_instr=0.
REQ-031 SHALL, on reset asserted mid-operation, discard all entries immediately without waiting for a clock edge.
REQ-032 SHALL accept the first push on the first rising edge after reset returns to 1.
REQ-033 SHALL leave storage array contents undefined after reset; they are never observable because out_* are gated by out_valid.

Verification
REQ-034 SHALL pass: reset=0 then 1, push PCs 0x3000,0x3004,0x3008,0x300C with out_ready=0 -> count=4, in_ready=0, out_pc=0x3000.
REQ-035 SHALL pass: from full, in_valid=1 with in_pc=0x3010 and out_ready=0 for 2 cycles -> count stays 4, 0x3010 never appears on out_pc.
REQ-036 SHALL pass: from full, out_ready=1 for 4 cycles -> out_pc sequence 0x3000,0x3004,0x3008,0x300C, then out_valid=0, out_pc=0, count=0.
REQ-037 SHALL pass: continuous in_valid=1 and out_ready=1 for 10 pushes starting 0x3000 -> count toggles 0,1,1,..., pointers wrap past 3, outputs 0x3000..0x3024 in order, one-cycle lag.
REQ-038 SHALL pass: count=3, flush=1 with in_valid=1 and out_ready=1 same cycle -> next cycle count=0, out_valid=0, in_ready=1, next push appears at head.
REQ-039 SHALL pass: count=2, reset driven 0 between clock edges -> out_valid=0 and count=0 before the next rising edge.
